// File: rtl/cpu_move_commit.sv
// cpu_move_commit: turns random column samples into a legal CPU move, with retry,
// deterministic scan fallback, think delay and human-move arbitration.
`default_nettype none

module cpu_move_commit #(
  parameter int COLS         = 5,
  parameter int ROWS         = 6,
  parameter int MAX_TRIES    = 8,
  parameter int THINK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_start,
  input  logic [3:0] i_rand_col,
  input  logic       i_human_valid,
  input  logic [3:0] i_human_col,
  output logic       o_busy,
  output logic       o_move_valid,
  output logic [3:0] o_move_col,
  output logic [2:0] o_move_row,
  output logic       o_no_move,
  output logic       o_board_full
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_THINK  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [2:0] C_ROWS = 3'(ROWS);

  logic [2:0] r_state;
  logic [2:0] r_height [COLS];
  logic [7:0] r_tries;
  logic [7:0] r_think;
  logic [3:0] r_idx;
  logic [3:0] r_cand;
  logic       r_busy;
  logic       r_move_valid;
  logic [3:0] r_move_col;
  logic [2:0] r_move_row;
  logic       r_no_move;
  logic       r_full;

  logic [2:0] w_rand_h;
  logic [2:0] w_cand_h;
  logic [2:0] w_idx_h;
  logic [2:0] w_human_h;
  logic       w_all_full;
  logic       w_human_ok;
  logic       w_rand_ok;
  logic       w_conflict;
  logic       w_commit;

  // Mux lookups keep out-of-range column indices from ever addressing the array.
  always_comb begin
    w_rand_h   = '0;
    w_cand_h   = '0;
    w_idx_h    = '0;
    w_human_h  = '0;
    w_all_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (i_rand_col == 4'(c))  w_rand_h  = r_height[c];
      if (r_cand == 4'(c))      w_cand_h  = r_height[c];
      if (r_idx == 4'(c))       w_idx_h   = r_height[c];
      if (i_human_col == 4'(c)) w_human_h = r_height[c];
      if (r_height[c] != C_ROWS) w_all_full = 1'b0;
    end
  end

  assign w_human_ok = i_human_valid && (i_human_col < 4'(COLS)) && (w_human_h < C_ROWS);
  assign w_rand_ok  = (i_rand_col < 4'(COLS)) && (w_rand_h < C_ROWS);
  // A legal human drop into the candidate column wins the COMMIT cycle.
  assign w_conflict = w_human_ok && (i_human_col == r_cand);
  assign w_commit   = (r_state == S_COMMIT) && (w_cand_h < C_ROWS) && !w_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      for (int c = 0; c < COLS; c++) r_height[c] <= '0;
      r_tries      <= '0;
      r_think      <= '0;
      r_idx        <= '0;
      r_cand       <= '0;
      r_busy       <= 1'b0;
      r_move_valid <= 1'b0;
      r_move_col   <= '0;
      r_move_row   <= '0;
      r_no_move    <= 1'b0;
      r_full       <= 1'b0;
    end else if (i_clear) begin
      r_state      <= S_IDLE;
      for (int c = 0; c < COLS; c++) r_height[c] <= '0;
      r_tries      <= '0;
      r_think      <= '0;
      r_idx        <= '0;
      r_cand       <= '0;
      r_busy       <= 1'b0;
      r_move_valid <= 1'b0;
      r_move_col   <= '0;
      r_move_row   <= '0;
      r_no_move    <= 1'b0;
      r_full       <= 1'b0;
    end else begin
      r_move_valid <= 1'b0;
      r_no_move    <= 1'b0;
      r_full       <= w_all_full;

      for (int c = 0; c < COLS; c++) begin
        if ((w_human_ok && i_human_col == 4'(c)) || (w_commit && r_cand == 4'(c)))
          r_height[c] <= r_height[c] + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (r_full) begin
              r_no_move <= 1'b1;
            end else begin
              r_state <= S_SAMPLE;
              r_tries <= '0;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SAMPLE: begin
          if (w_rand_ok) begin
            r_cand  <= i_rand_col;
            r_think <= '0;
            r_state <= S_THINK;
          end else if (r_tries == 8'(MAX_TRIES - 1)) begin
            r_idx   <= '0;
            r_state <= S_SCAN;
          end else begin
            r_tries <= r_tries + 8'd1;
          end
        end
        S_SCAN: begin
          if (w_idx_h < C_ROWS) begin
            r_cand  <= r_idx;
            r_think <= '0;
            r_state <= S_THINK;
          end else if (r_idx == 4'(COLS - 1)) begin
            r_no_move <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_THINK: begin
          if (r_think == 8'(THINK_CYCLES - 1)) r_state <= S_COMMIT;
          else                                  r_think <= r_think + 8'd1;
        end
        S_COMMIT: begin
          if (w_commit) begin
            r_move_col   <= r_cand;
            r_move_row   <= w_cand_h;
            r_move_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_tries <= '0;
            r_state <= S_SAMPLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_move_valid = r_move_valid;
  assign o_move_col   = r_move_col;
  assign o_move_row   = r_move_row;
  assign o_no_move    = r_no_move;
  assign o_board_full = r_full;

endmodule

`default_nettype wire

// File: tb/tb_cpu_move_commit.sv
// tb_cpu_move_commit: scenario tasks plus randomized moves checked against a
// transaction-level model of column heights and move timing.
`default_nettype none

module tb_cpu_move_commit;
  localparam int COLS = 5, ROWS = 6, MAX_TRIES = 8, THINK_CYCLES = 4;

  logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0, human_valid = 1'b0;
  logic [3:0] rand_col = '0, human_col = '0;
  logic       busy, move_valid, no_move, board_full;
  logic [3:0] move_col;
  logic [2:0] move_row;

  int n_vec = 0, n_err = 0;
  int m_h [COLS];
  int seq [64];

  cpu_move_commit #(.COLS(COLS), .ROWS(ROWS), .MAX_TRIES(MAX_TRIES), .THINK_CYCLES(THINK_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(clear), .i_start(start), .i_rand_col(rand_col),
    .i_human_valid(human_valid), .i_human_col(human_col), .o_busy(busy),
    .o_move_valid(move_valid), .o_move_col(move_col), .o_move_row(move_row),
    .o_no_move(no_move), .o_board_full(board_full));

  always #5 clk = ~clk;

  function automatic bit legal(int c);
    return c >= 0 && c < COLS && m_h[c] < ROWS;
  endfunction

  function automatic bit model_full();
    for (int c = 0; c < COLS; c++) if (m_h[c] < ROWS) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_zero();
    for (int c = 0; c < COLS; c++) m_h[c] = 0;
  endtask

  task automatic fill_seq(int v);
    for (int i = 0; i < 64; i++) seq[i] = v;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_zero();
  endtask

  task automatic human_drop(int c);
    @(negedge clk); human_valid = 1'b1; human_col = 4'(c);
    @(posedge clk); if (legal(c)) m_h[c]++;
    @(negedge clk); human_valid = 1'b0;
  endtask

  // One full CPU request; expected timing comes from counting rejections.
  task automatic run_move(input int hum_c, input string tag);
    int acc, cand, fin, row;
    bit nm, hum_use;
    acc = -1; cand = 0; nm = 1'b0; fin = 0;
    if (model_full()) nm = 1'b1;
    else begin
      for (int i = 0; i < MAX_TRIES; i++)
        if (acc < 0 && legal(seq[i])) begin acc = i + 1; cand = seq[i]; end
      for (int j = 0; j < COLS; j++)
        if (acc < 0 && m_h[j] < ROWS) begin acc = MAX_TRIES + 1 + j; cand = j; end
      if (acc < 0) begin nm = 1'b1; fin = MAX_TRIES + COLS; end
      else fin = acc + THINK_CYCLES + 1;
    end
    hum_use = !nm && hum_c >= 0 && hum_c != cand;
    row = m_h[cand];
    for (int n = 0; n <= fin + 1; n++) begin
      @(negedge clk);
      start = (n == 0);
      rand_col = (n == 0) ? 4'd0 : 4'(seq[n-1]);
      human_valid = hum_use && n == fin;
      human_col = 4'(hum_c < 0 ? 0 : hum_c);
      @(posedge clk); #1;
      n_vec++;
      if (busy !== (!(nm && fin == 0) && n < fin)) begin
        n_err++; $display("FAIL %s busy edge %0d: got %b", tag, n, busy);
      end
      n_vec++;
      if (move_valid !== (!nm && n == fin)) begin
        n_err++; $display("FAIL %s move_valid edge %0d: got %b", tag, n, move_valid);
      end
      n_vec++;
      if (no_move !== (nm && n == fin)) begin
        n_err++; $display("FAIL %s no_move edge %0d: got %b", tag, n, no_move);
      end
      if (!nm && n == fin) begin
        m_h[cand]++;
        if (hum_use && legal(hum_c)) m_h[hum_c]++;
      end
      if (!nm && n >= fin) begin
        n_vec++;
        if (move_col !== 4'(cand) || move_row !== 3'(row)) begin
          n_err++;
          $display("FAIL %s move col/row edge %0d: got %0d/%0d want %0d/%0d", tag, n, move_col, move_row, cand, row);
        end
      end
    end
    human_valid = 1'b0;
    n_vec++;
    if (board_full !== model_full()) begin
      n_err++; $display("FAIL %s board_full: got %b want %b", tag, board_full, model_full());
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({busy, move_valid, no_move, board_full, move_col, move_row} !== 11'd0) begin
      n_err++; $display("FAIL reset outputs: got %b %b %b %b %0d %0d", busy, move_valid, no_move, board_full, move_col, move_row);
    end
    @(negedge clk); rst_n = 1'b1;
    model_zero();
  endtask

  task automatic test_basic();
    fill_seq(2); run_move(-1, "basic");
  endtask

  task automatic test_reject();
    do_clear();
    for (int k = 0; k < ROWS; k++) human_drop(2);
    fill_seq(3); seq[0] = 2; seq[1] = 2;
    run_move(-1, "reject");
  endtask

  task automatic test_scan();
    do_clear(); fill_seq(7); run_move(-1, "scan");
  endtask

  task automatic test_full();
    do_clear();
    for (int c = 0; c < 4; c++) for (int k = 0; k < ROWS; k++) human_drop(c);
    for (int k = 0; k < ROWS - 1; k++) human_drop(4);
    fill_seq(9); run_move(-1, "fill_last");
    run_move(-1, "full_start");
  endtask

  task automatic test_side_human();
    do_clear(); fill_seq(3); run_move(4, "side_commit");
    fill_seq(4); run_move(-1, "side_after");
  endtask

  task automatic test_conflict();
    do_clear();
    for (int k = 0; k < ROWS - 1; k++) human_drop(1);
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      start = (n == 0);
      rand_col = (n <= 7) ? 4'd1 : 4'd0;
      human_valid = (n == 6); human_col = 4'd1;
      @(posedge clk); #1;
      n_vec++;
      if (move_valid !== (n == 13) || busy !== (n < 13)) begin
        n_err++; $display("FAIL conflict edge %0d: move_valid=%b busy=%b", n, move_valid, busy);
      end
      if (n == 13) begin
        n_vec++;
        if (move_col !== 4'd0 || move_row !== 3'd0) begin
          n_err++; $display("FAIL conflict move: got %0d/%0d want 0/0", move_col, move_row);
        end
      end
    end
    human_valid = 1'b0;
    m_h[1] = ROWS; m_h[0] = 1;
    fill_seq(1); seq[0] = 2; run_move(-1, "conflict_after");
  endtask

  task automatic test_reset_mid();
    do_clear();
    human_drop(2);
    @(negedge clk); start = 1'b1; rand_col = 4'd2;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); @(negedge clk); start = 1'b0;
    end
    rst_n = 1'b0; #1;
    n_vec++;
    if ({busy, move_valid, no_move, board_full, move_col, move_row} !== 11'd0) begin
      n_err++; $display("FAIL reset_mid outputs: got busy=%b", busy);
    end
    model_zero();
    @(negedge clk); rst_n = 1'b1;
    fill_seq(2); run_move(-1, "after_reset");
  endtask

  task automatic test_clear_mid();
    human_drop(0);
    @(negedge clk); start = 1'b1; rand_col = 4'd7;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); clear = 1'b0; model_zero();
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0 || no_move !== 1'b0 || move_valid !== 1'b0 || move_col !== 4'd0) begin
        n_err++; $display("FAIL clear_mid cycle %0d: busy=%b no_move=%b move_valid=%b col=%0d", n, busy, no_move, move_valid, move_col);
      end
    end
  endtask

  task automatic test_random();
    int hc;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      repeat ($urandom_range(0, 4)) human_drop(int'($urandom_range(0, 6)));
      for (int i = 0; i < 64; i++)
        seq[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
      hc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_move(hc, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_scan();
    test_full();
    test_side_human();
    test_conflict();
    test_reset_mid();
    test_clear_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
